// File: rtl/vga_timing_param.sv
// vga_timing_param
// Parametrised VGA timing generator. Stage-0 counters produce active-area
// coordinates ahead of the video. Sync and active flags travel through a
// PIPE_DELAY-deep delay line so that pixel data from a source with
// PIPE_DELAY ticks of latency lines up with the registered sync outputs.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a TestMode input that
// replaces RGB with eight vertical colour bars.
module vga_timing_param #(
    parameter int COLOR_W    = 8,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int PIPE_DELAY = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 PixelEn,
    input  logic [3*COLOR_W-1:0] RGB,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 TestMode,
`endif
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 blank,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic [9:0]           ColunaOut,
    output logic [9:0]           LinhaOut,
    output logic                 PixelReq,
    output logic                 FrameStart,
    output logic                 LineStart
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_FIRST = H_SYNC + H_BP;
    localparam int V_ACT_FIRST = V_SYNC + V_BP;

    localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_AF_C    = 10'(H_ACT_FIRST);
    localparam logic [9:0] H_AL_C    = 10'(H_ACT_FIRST + H_ACTIVE - 1);
    localparam logic [9:0] V_AF_C    = 10'(V_ACT_FIRST);
    localparam logic [9:0] V_AL_C    = 10'(V_ACT_FIRST + V_ACTIVE - 1);
    localparam logic       HP        = (H_POL != 0);
    localparam logic       VP        = (V_POL != 0);

    // Counters are 10 bits wide, so totals beyond 1024 cannot be represented.
    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_timing_param: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_timing_param: V_TOTAL exceeds 1024");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_chk
        $error("vga_timing_param: PIPE_DELAY must be 1..4");
    end

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_hs0;
    logic       w_vs0;
    logic       w_h_act;
    logic       w_v_act;
    logic       w_act0;
    logic [9:0] w_x0;
    logic [9:0] w_y0;

    logic [PIPE_DELAY-1:0] r_dly_hs;
    logic [PIPE_DELAY-1:0] r_dly_vs;
    logic [PIPE_DELAY-1:0] r_dly_act;
    logic                  w_hs_d;
    logic                  w_vs_d;
    logic                  w_act_d;
    logic [3*COLOR_W-1:0]  w_rgb;

    logic                  r_h_sync;
    logic                  r_v_sync;
    logic                  r_blank;
    logic [COLOR_W-1:0]    r_r;
    logic [COLOR_W-1:0]    r_g;
    logic [COLOR_W-1:0]    r_b;

    // Stage-0 raster counters: column wraps at the line end, line wraps at the frame end.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (PixelEn) begin
            if (r_hcnt == H_LAST_C) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST_C) ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    assign w_hs0   = (r_hcnt < H_SYNC_C);
    assign w_vs0   = (r_vcnt < V_SYNC_C);
    assign w_h_act = (r_hcnt >= H_AF_C) && (r_hcnt <= H_AL_C);
    assign w_v_act = (r_vcnt >= V_AF_C) && (r_vcnt <= V_AL_C);
    assign w_act0  = w_h_act && w_v_act;
    assign w_x0    = w_act0 ? (r_hcnt - H_AF_C) : 10'd0;
    assign w_y0    = w_act0 ? (r_vcnt - V_AF_C) : 10'd0;

    assign ColunaOut  = w_x0;
    assign LinhaOut   = w_y0;
    assign PixelReq   = w_act0;
    assign FrameStart = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    assign LineStart  = (r_hcnt == 10'd0);

    // Delay line that matches the stage-0 flags to the pixel-source latency.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_dly_hs  <= '0;
            r_dly_vs  <= '0;
            r_dly_act <= '0;
        end else if (PixelEn) begin
            r_dly_hs[0]  <= w_hs0;
            r_dly_vs[0]  <= w_vs0;
            r_dly_act[0] <= w_act0;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_dly_hs[i]  <= r_dly_hs[i-1];
                r_dly_vs[i]  <= r_dly_vs[i-1];
                r_dly_act[i] <= r_dly_act[i-1];
            end
        end
    end

    assign w_hs_d  = r_dly_hs[PIPE_DELAY-1];
    assign w_vs_d  = r_dly_vs[PIPE_DELAY-1];
    assign w_act_d = r_dly_act[PIPE_DELAY-1];

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W_C = 10'(H_ACTIVE / 8);

    logic [9:0] r_dly_x [PIPE_DELAY];
    logic [2:0] w_bar;

    // The x coordinate follows the same delay as the active flag for the bar pattern.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_dly_x[i] <= '0;
            end
        end else if (PixelEn) begin
            r_dly_x[0] <= w_x0;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_dly_x[i] <= r_dly_x[i-1];
            end
        end
    end

    assign w_bar = 3'(r_dly_x[PIPE_DELAY-1] / BAR_W_C);

    // Colour source select: bars replace RGB while TestMode is high.
    always_comb begin
        w_rgb = RGB;
        if (TestMode) begin
            w_rgb = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
        end
    end
`else
    assign w_rgb = RGB;
`endif

    // Output register: polarity-adjusted syncs, blank_n and colour gated by the active flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_h_sync <= ~HP;
            r_v_sync <= ~VP;
            r_blank  <= 1'b0;
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
        end else if (PixelEn) begin
            r_h_sync <= ~(w_hs_d ^ HP);
            r_v_sync <= ~(w_vs_d ^ VP);
            r_blank  <= w_act_d;
            if (w_act_d) begin
                {r_r, r_g, r_b} <= w_rgb;
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign h_sync = r_h_sync;
    assign v_sync = r_v_sync;
    assign blank  = r_blank;
    assign R      = r_r;
    assign G      = r_g;
    assign B      = r_b;

endmodule

// File: tb/tb_vga_timing_param.sv
// Testbench for vga_timing_param. Two instances with small raster sizes:
//   A: 4/3/16/2 x 2/2/6/1 (25x11 ticks), active-low syncs, PIPE_DELAY=2
//   B: 3/2/8/1  x 1/1/4/2 (14x8 ticks),  active-high syncs, PIPE_DELAY=1
// Per-frame figures for A: h_sync low 44, v_sync low 50, visible 96.
// Per-frame figures for B: h_sync high 24, v_sync high 14, visible 32.
module tb_vga_timing_param;

    localparam int A_FRAME = 275;
    localparam int A_LINE  = 25;
    localparam int B_FRAME = 112;

    logic        Clock;
    logic        Reset;
    logic        PixelEn;
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;

    logic       a_hs, a_vs, a_blank, a_req, a_fs, a_ls;
    logic [7:0] a_r, a_g, a_b;
    logic [9:0] a_col, a_lin;
    logic       b_hs, b_vs, b_blank, b_req, b_fs, b_ls;
    logic [7:0] b_r, b_g, b_b;
    logic [9:0] b_col, b_lin;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    vga_timing_param #(
        .COLOR_W(8), .H_SYNC(4), .H_BP(3), .H_ACTIVE(16), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(6), .V_FP(1),
        .H_POL(0), .V_POL(0), .PIPE_DELAY(2)
    ) u_dut_a (
        .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn), .RGB(rgb_a),
`ifdef VGA_TEST_PATTERN_EN
        .TestMode(1'b0),
`endif
        .h_sync(a_hs), .v_sync(a_vs), .blank(a_blank),
        .R(a_r), .G(a_g), .B(a_b),
        .ColunaOut(a_col), .LinhaOut(a_lin), .PixelReq(a_req),
        .FrameStart(a_fs), .LineStart(a_ls)
    );

    vga_timing_param #(
        .COLOR_W(8), .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(2),
        .H_POL(1), .V_POL(1), .PIPE_DELAY(1)
    ) u_dut_b (
        .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn), .RGB(rgb_b),
`ifdef VGA_TEST_PATTERN_EN
        .TestMode(1'b0),
`endif
        .h_sync(b_hs), .v_sync(b_vs), .blank(b_blank),
        .R(b_r), .G(b_g), .B(b_b),
        .ColunaOut(b_col), .LinhaOut(b_lin), .PixelReq(b_req),
        .FrameStart(b_fs), .LineStart(b_ls)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference raster decode: stage-0 flags and coordinates for tick index idx.
    function automatic void decode(input int idx, input int hs, input int hb, input int ha,
                                   input int hf, input int vs, input int vb, input int va,
                                   input int vf, output logic o_hs, output logic o_vs,
                                   output logic o_act, output int o_x, output int o_y);
        int ht, vt, h, v;
        ht = hs + hb + ha + hf;
        vt = vs + vb + va + vf;
        o_hs = 1'b0; o_vs = 1'b0; o_act = 1'b0; o_x = 0; o_y = 0;
        if (idx < 0) return;
        h = idx % ht;
        v = (idx / ht) % vt;
        o_hs  = (h < hs);
        o_vs  = (v < vs);
        o_act = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
        if (o_act) begin
            o_x = h - (hs + hb);
            o_y = v - (vs + vb);
        end
    endfunction

    // Driver: sets pixel-source data for the coming edge, then advances one clock.
    task automatic step(input logic en);
        logic ehs, evs, eact;
        int   ex, ey;
        PixelEn = en;
        if (en) begin
            decode(cnt - 2, 4, 3, 16, 2, 2, 2, 6, 1, ehs, evs, eact, ex, ey);
            rgb_a = eact ? {8'(ex), 8'(ey), 8'hA5} : 24'hFFFFFF;
        end
        @(posedge Clock);
        #1;
        if (en && Reset) cnt++;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step(1'b1);
        step(1'b1);
        Reset = 1'b1;
        cnt = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        PixelEn = 1'b0;
        rgb_a = 24'hFFFFFF;
        rgb_b = 24'h3C5AC3;
        cnt = 0;
        step(1'b1);
        step(1'b1);
        checks++; if (a_hs !== 1'b1) begin failures++; $display("FAIL reset_a_hs got=%b exp=1", a_hs); end
        checks++; if (a_vs !== 1'b1) begin failures++; $display("FAIL reset_a_vs got=%b exp=1", a_vs); end
        checks++; if (a_blank !== 1'b0) begin failures++; $display("FAIL reset_a_blank got=%b exp=0", a_blank); end
        checks++; if ({a_r, a_g, a_b} !== 24'h0) begin failures++; $display("FAIL reset_a_rgb got=%h exp=0", {a_r, a_g, a_b}); end
        checks++; if (a_fs !== 1'b1 || a_ls !== 1'b1) begin failures++; $display("FAIL reset_a_starts got=%b%b exp=11", a_fs, a_ls); end
        checks++; if (a_col !== 10'd0 || a_req !== 1'b0) begin failures++; $display("FAIL reset_a_coord got=%0d/%b exp=0/0", a_col, a_req); end
        checks++; if (b_hs !== 1'b0 || b_vs !== 1'b0) begin failures++; $display("FAIL reset_b_sync got=%b%b exp=00", b_hs, b_vs); end
        checks++; if (b_blank !== 1'b0) begin failures++; $display("FAIL reset_b_blank got=%b exp=0", b_blank); end
        Reset = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        step(1'b1);
        checks++; if (b_hs !== 1'b0) begin failures++; $display("FAIL lat_b_t1 got=%b exp=0", b_hs); end
        step(1'b1);
        checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1) begin failures++; $display("FAIL lat_b_t2 got=%b%b exp=11", b_hs, b_vs); end
        checks++; if (a_hs !== 1'b1) begin failures++; $display("FAIL lat_a_t2 got=%b exp=1", a_hs); end
        step(1'b1);
        checks++; if (a_hs !== 1'b0 || a_vs !== 1'b0) begin failures++; $display("FAIL lat_a_t3 got=%b%b exp=00", a_hs, a_vs); end
    endtask

    task automatic test_frame_counts();
        int ahs = 0, avs = 0, abl = 0, bhs = 0, bvs = 0, bbl = 0, afs = 0, als = 0;
        do_reset();
        for (int i = 0; i < 553; i++) begin
            step(1'b1);
            if (cnt >= 3 && cnt < 553) begin
                ahs += (a_hs == 1'b0) ? 1 : 0;
                avs += (a_vs == 1'b0) ? 1 : 0;
                abl += (a_blank == 1'b1) ? 1 : 0;
            end
            if (cnt >= 2 && cnt < 226) begin
                bhs += (b_hs == 1'b1) ? 1 : 0;
                bvs += (b_vs == 1'b1) ? 1 : 0;
                bbl += (b_blank == 1'b1) ? 1 : 0;
            end
            if (cnt <= 550) begin
                afs += (a_fs == 1'b1) ? 1 : 0;
                als += (a_ls == 1'b1) ? 1 : 0;
            end
        end
        checks++; if (ahs != 88) begin failures++; $display("FAIL count_a_hs got=%0d exp=88", ahs); end
        checks++; if (avs != 100) begin failures++; $display("FAIL count_a_vs got=%0d exp=100", avs); end
        checks++; if (abl != 192) begin failures++; $display("FAIL count_a_blank got=%0d exp=192", abl); end
        checks++; if (afs != 2) begin failures++; $display("FAIL count_a_framestart got=%0d exp=2", afs); end
        checks++; if (als != 22) begin failures++; $display("FAIL count_a_linestart got=%0d exp=22", als); end
        checks++; if (bhs != 48) begin failures++; $display("FAIL count_b_hs_high got=%0d exp=48", bhs); end
        checks++; if (bvs != 28) begin failures++; $display("FAIL count_b_vs_high got=%0d exp=28", bvs); end
        checks++; if (bbl != 64) begin failures++; $display("FAIL count_b_blank got=%0d exp=64", bbl); end
    endtask

    task automatic test_alignment();
        logic ehs, evs, eact;
        int   ex, ey;
        for (int i = 0; i < 320; i++) begin
            step(1'b1);
            decode(cnt - 3, 4, 3, 16, 2, 2, 2, 6, 1, ehs, evs, eact, ex, ey);
            checks++; if (a_hs !== ~ehs || a_vs !== ~evs) begin failures++; $display("FAIL align_a_sync cnt=%0d got=%b%b exp=%b%b", cnt, a_hs, a_vs, ~ehs, ~evs); end
            checks++; if (a_blank !== eact) begin failures++; $display("FAIL align_a_blank cnt=%0d got=%b exp=%b", cnt, a_blank, eact); end
            checks++; if ({a_r, a_g, a_b} !== (eact ? {8'(ex), 8'(ey), 8'hA5} : 24'h0)) begin failures++; $display("FAIL align_a_rgb cnt=%0d got=%h exp=%h", cnt, {a_r, a_g, a_b}, eact ? {8'(ex), 8'(ey), 8'hA5} : 24'h0); end
            decode(cnt, 4, 3, 16, 2, 2, 2, 6, 1, ehs, evs, eact, ex, ey);
            checks++; if (a_req !== eact || a_col !== 10'(ex) || a_lin !== 10'(ey)) begin failures++; $display("FAIL align_a_coord cnt=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cnt, a_req, a_col, a_lin, eact, ex, ey); end
            decode(cnt - 2, 3, 2, 8, 1, 1, 1, 4, 2, ehs, evs, eact, ex, ey);
            checks++; if (b_hs !== ehs || b_vs !== evs || b_blank !== eact) begin failures++; $display("FAIL align_b_pins cnt=%0d got=%b%b%b exp=%b%b%b", cnt, b_hs, b_vs, b_blank, ehs, evs, eact); end
            checks++; if ({b_r, b_g, b_b} !== (eact ? 24'h3C5AC3 : 24'h0)) begin failures++; $display("FAIL align_b_rgb cnt=%0d got=%h exp=%h", cnt, {b_r, b_g, b_b}, eact ? 24'h3C5AC3 : 24'h0); end
            decode(cnt, 3, 2, 8, 1, 1, 1, 4, 2, ehs, evs, eact, ex, ey);
            checks++; if (b_req !== eact || b_col !== 10'(ex) || b_lin !== 10'(ey) || b_fs !== ((cnt % B_FRAME) == 0)) begin failures++; $display("FAIL align_b_coord cnt=%0d got=%b/%0d/%0d/%b exp=%b/%0d/%0d", cnt, b_req, b_col, b_lin, b_fs, eact, ex, ey); end
        end
    endtask

    task automatic run_to(input int m);
        for (int i = 0; i < 2 * A_FRAME && (cnt % A_FRAME) != m; i++) step(1'b1);
    endtask

    task automatic test_boundary();
        run_to(107);
        checks++; if (a_req !== 1'b1 || a_col !== 10'd0 || a_lin !== 10'd0) begin failures++; $display("FAIL bnd_first_pixel got=%b/%0d/%0d exp=1/0/0", a_req, a_col, a_lin); end
        run_to(247);
        checks++; if (a_req !== 1'b1 || a_col !== 10'd15 || a_lin !== 10'd5) begin failures++; $display("FAIL bnd_last_pixel got=%b/%0d/%0d exp=1/15/5", a_req, a_col, a_lin); end
        step(1'b1);
        checks++; if (a_req !== 1'b0 || a_col !== 10'd0 || a_lin !== 10'd0) begin failures++; $display("FAIL bnd_after_last got=%b/%0d/%0d exp=0/0/0", a_req, a_col, a_lin); end
        run_to(274);
        checks++; if (a_fs !== 1'b0 || a_ls !== 1'b0) begin failures++; $display("FAIL bnd_frame_end got=%b%b exp=00", a_fs, a_ls); end
        step(1'b1);
        checks++; if (a_fs !== 1'b1 || a_ls !== 1'b1) begin failures++; $display("FAIL bnd_wrap got=%b%b exp=11", a_fs, a_ls); end
        step(1'b1);
        checks++; if (a_fs !== 1'b0 || a_ls !== 1'b0) begin failures++; $display("FAIL bnd_after_wrap got=%b%b exp=00", a_fs, a_ls); end
        run_to(A_LINE);
        checks++; if (a_fs !== 1'b0 || a_ls !== 1'b1) begin failures++; $display("FAIL bnd_line1 got=%b%b exp=01", a_fs, a_ls); end
    endtask

    task automatic test_pixel_en_toggle();
        logic ehs, evs, eact;
        int   ex, ey;
        int   ahs = 0, abl = 0;
        do_reset();
        for (int i = 0; i < 553; i++) begin
            step(1'b1);
            if (cnt >= 3 && cnt < 553) begin
                ahs += (a_hs == 1'b0) ? 1 : 0;
                abl += (a_blank == 1'b1) ? 1 : 0;
            end
            step(1'b0);
            if (cnt >= 3 && cnt < 553) begin
                ahs += (a_hs == 1'b0) ? 1 : 0;
                abl += (a_blank == 1'b1) ? 1 : 0;
            end
            if ((i % 37) == 5) begin
                decode(cnt - 3, 4, 3, 16, 2, 2, 2, 6, 1, ehs, evs, eact, ex, ey);
                checks++; if (a_hs !== ~ehs || a_blank !== eact || {a_r, a_g, a_b} !== (eact ? {8'(ex), 8'(ey), 8'hA5} : 24'h0)) begin failures++; $display("FAIL hold_a_pins cnt=%0d got=%b%b/%h exp=%b%b", cnt, a_hs, a_blank, {a_r, a_g, a_b}, ~ehs, eact); end
                decode(cnt, 4, 3, 16, 2, 2, 2, 6, 1, ehs, evs, eact, ex, ey);
                checks++; if (a_col !== 10'(ex) || a_req !== eact) begin failures++; $display("FAIL hold_a_coord cnt=%0d got=%0d/%b exp=%0d/%b", cnt, a_col, a_req, ex, eact); end
            end
        end
        checks++; if (ahs != 176) begin failures++; $display("FAIL toggle_a_hs got=%0d exp=176", ahs); end
        checks++; if (abl != 384) begin failures++; $display("FAIL toggle_a_blank got=%0d exp=384", abl); end
    endtask

    task automatic test_reset_mid();
        int ahs = 0, avs = 0, abl = 0;
        do_reset();
        for (int i = 0; i < 5 * A_LINE + 10; i++) step(1'b1);
        checks++; if (a_req !== 1'b1 || a_col !== 10'd3 || a_lin !== 10'd1) begin failures++; $display("FAIL mid_pre got=%b/%0d/%0d exp=1/3/1", a_req, a_col, a_lin); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (a_hs !== 1'b1 || a_vs !== 1'b1 || a_blank !== 1'b0) begin failures++; $display("FAIL mid_async_sync got=%b%b%b exp=110", a_hs, a_vs, a_blank); end
        checks++; if ({a_r, a_g, a_b} !== 24'h0 || a_col !== 10'd0 || a_fs !== 1'b1) begin failures++; $display("FAIL mid_async_state got=%h/%0d/%b exp=0/0/1", {a_r, a_g, a_b}, a_col, a_fs); end
        checks++; if (b_hs !== 1'b0 || b_vs !== 1'b0) begin failures++; $display("FAIL mid_async_b got=%b%b exp=00", b_hs, b_vs); end
        step(1'b1);
        step(1'b1);
        Reset = 1'b1;
        cnt = 0;
        checks++; if (a_fs !== 1'b1 || a_ls !== 1'b1) begin failures++; $display("FAIL mid_release_fs got=%b%b exp=11", a_fs, a_ls); end
        for (int i = 0; i < A_FRAME + 3; i++) begin
            step(1'b1);
            if (cnt >= 3 && cnt < A_FRAME + 3) begin
                ahs += (a_hs == 1'b0) ? 1 : 0;
                avs += (a_vs == 1'b0) ? 1 : 0;
                abl += (a_blank == 1'b1) ? 1 : 0;
            end
        end
        checks++; if (ahs != 44 || avs != 50) begin failures++; $display("FAIL mid_frame_sync got=%0d/%0d exp=44/50", ahs, avs); end
        checks++; if (abl != 96) begin failures++; $display("FAIL mid_frame_blank got=%0d exp=96", abl); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame_counts();
        test_alignment();
        test_boundary();
        test_pixel_en_toggle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
